// File: rtl/fpu_exp_adjust_pipe_if.sv
// Bus interface for the exponent-adjust pipeline: upstream beat fields,
// downstream result fields, valid/ready handshakes and sticky controls.
interface fpu_exp_adjust_pipe_if #(
  parameter int SIZE_EXP  = 8,
  parameter int SIZE_LOPD = 8,
  parameter int SIZE_TAG  = 1
);
  logic                 i_valid;
  logic                 o_ready;
  logic                 i_overflow;
  logic                 i_underflow;
  logic                 i_zero_flag;
  logic [SIZE_LOPD-1:0] i_lopd_value;
  logic [SIZE_EXP-1:0]  i_exp_value;
  logic [SIZE_TAG-1:0]  i_tag;
  logic                 i_clr_sticky;
  logic                 o_valid;
  logic                 i_ready;
  logic [SIZE_EXP-1:0]  o_exp_result;
  logic [SIZE_TAG-1:0]  o_tag;
  logic                 o_exp_ovf;
  logic                 o_exp_unf;
  logic                 o_sticky_ovf;
  logic                 o_sticky_unf;

  // The pipeline itself sees the bus from this side
  modport slave (
    input  i_valid, i_overflow, i_underflow, i_zero_flag, i_lopd_value,
           i_exp_value, i_tag, i_clr_sticky, i_ready,
    output o_ready, o_valid, o_exp_result, o_tag, o_exp_ovf, o_exp_unf,
           o_sticky_ovf, o_sticky_unf
  );

  // Whoever feeds and drains the pipeline sees it from this side
  modport master (
    output i_valid, i_overflow, i_underflow, i_zero_flag, i_lopd_value,
           i_exp_value, i_tag, i_clr_sticky, i_ready,
    input  o_ready, o_valid, o_exp_result, o_tag, o_exp_ovf, o_exp_unf,
           o_sticky_ovf, o_sticky_unf
  );
endinterface

// File: rtl/fpu_exp_adjust_pipe.sv
// Two-stage exponent adjuster between the LOPD/normaliser and the packer.
// S1 forms the signed adjusted exponent, S2 range-limits it (saturate high,
// flush low) and raises per-beat flags; sticky flags accumulate what the
// downstream actually consumed.
module fpu_exp_adjust_pipe #(
  parameter int SIZE_EXP  = 8,
  parameter int SIZE_LOPD = 8,
  parameter int SIZE_TAG  = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  fpu_exp_adjust_pipe_if.slave   bus
);
  // Two guard bits: one for the +1 carry, one for the sign of exp - lopd
  localparam int W = ((SIZE_EXP > SIZE_LOPD) ? SIZE_EXP : SIZE_LOPD) + 2;
  localparam logic [W-1:0] MAX_W = {{(W-SIZE_EXP){1'b0}}, {SIZE_EXP{1'b1}}};

  logic                r_s1Valid;
  logic [W-1:0]        r_s1Exp;
  logic                r_s1Zero;
  logic [SIZE_TAG-1:0] r_s1Tag;

  logic                r_s2Valid;
  logic [SIZE_EXP-1:0] r_s2Result;
  logic [SIZE_TAG-1:0] r_s2Tag;
  logic                r_s2Ovf;
  logic                r_s2Unf;

  logic                r_stickyOvf;
  logic                r_stickyUnf;

  logic [W-1:0]        w_expExt;
  logic [W-1:0]        w_lopdExt;
  logic [W-1:0]        w_s1Next;
  logic                w_s2Load;
  logic                w_s1Load;
  logic                w_accept;
  logic                w_outFire;
  logic                w_isNeg;
  logic                w_geMax;
  logic                w_le0;
  logic [SIZE_EXP-1:0] w_result;
  logic                w_ovf;
  logic                w_unf;

  assign w_expExt  = {{(W-SIZE_EXP){1'b0}}, bus.i_exp_value};
  assign w_lopdExt = {{(W-SIZE_LOPD){1'b0}}, bus.i_lopd_value};

  // A stage may load when empty or when its content leaves this cycle;
  // o_ready is therefore just "S1 may load", giving full throughput.
  assign w_s2Load  = ~r_s2Valid | bus.i_ready;
  assign w_s1Load  = ~r_s1Valid | w_s2Load;
  assign w_accept  = bus.i_valid & w_s1Load;
  assign w_outFire = r_s2Valid & bus.i_ready;

  assign bus.o_ready      = w_s1Load;
  assign bus.o_valid      = r_s2Valid;
  assign bus.o_exp_result = r_s2Result;
  assign bus.o_tag        = r_s2Tag;
  assign bus.o_exp_ovf    = r_s2Ovf;
  assign bus.o_exp_unf    = r_s2Unf;
  assign bus.o_sticky_ovf = r_stickyOvf;
  assign bus.o_sticky_unf = r_stickyUnf;

  // S1 exponent adjustment: carry-out beats normalised beats beats LOPD shift
  always_comb begin
    w_s1Next = w_expExt - w_lopdExt;
    if (bus.i_overflow) begin
      w_s1Next = w_expExt + W'(1);
    end else if (bus.i_underflow) begin
      w_s1Next = w_expExt;
    end
  end

  // Range tests done on the sign bit and an unsigned compare of the
  // non-negative range, so no signed arithmetic semantics are involved
  assign w_isNeg = r_s1Exp[W-1];
  assign w_geMax = ~w_isNeg & (r_s1Exp >= MAX_W);
  assign w_le0   = w_isNeg | (r_s1Exp == '0);

  // S2 classification: a zero mantissa overrides any range condition
  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    w_unf    = 1'b0;
    if (r_s1Zero) begin
      w_result = '0;
    end else if (w_geMax) begin
      w_result = '1;
      w_ovf    = 1'b1;
    end else if (w_le0) begin
      w_unf    = 1'b1;
    end else begin
      w_result = r_s1Exp[SIZE_EXP-1:0];
    end
  end

  // S1 register: capture the adjusted exponent and sideband of accepted beats
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1Valid <= 1'b0;
      r_s1Exp   <= '0;
      r_s1Zero  <= 1'b0;
      r_s1Tag   <= '0;
    end else if (w_s1Load) begin
      r_s1Valid <= bus.i_valid;
      if (bus.i_valid) begin
        r_s1Exp  <= w_s1Next;
        r_s1Zero <= bus.i_zero_flag;
        r_s1Tag  <= bus.i_tag;
      end
    end
  end

  // S2 register: the output stage, held stable while the downstream stalls
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s2Valid  <= 1'b0;
      r_s2Result <= '0;
      r_s2Tag    <= '0;
      r_s2Ovf    <= 1'b0;
      r_s2Unf    <= 1'b0;
    end else if (w_s2Load) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Result <= w_result;
        r_s2Tag    <= r_s1Tag;
        r_s2Ovf    <= w_ovf;
        r_s2Unf    <= w_unf;
      end
    end
  end

  // Sticky flags record consumed exceptions; a set in the same cycle as a clear wins
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stickyOvf <= 1'b0;
      r_stickyUnf <= 1'b0;
    end else begin
      if (w_outFire & r_s2Ovf) begin
        r_stickyOvf <= 1'b1;
      end else if (bus.i_clr_sticky) begin
        r_stickyOvf <= 1'b0;
      end
      if (w_outFire & r_s2Unf) begin
        r_stickyUnf <= 1'b1;
      end else if (bus.i_clr_sticky) begin
        r_stickyUnf <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fpu_exp_adjust_pipe.md
Name: fpu_exp_adjust_pipe

Overview:
- Pipelined, parametrised exponent-adjust stage for the FPU add/sub datapath used by the FFT butterflies.
- Takes the pre-normalisation exponent, the mantissa overflow/underflow/zero indications and the LOPD shift count, and produces the final biased exponent.
- Adds what the combinational adjuster lacks: range checking with saturation to all-ones and flush-to-zero, per-result and sticky exception flags, sideband tag passthrough, and valid/ready flow control.
- Sits between the LOPD/normaliser and the result packer.

Parameters:
- SIZE_EXP, 8, exponent width in bits.
- SIZE_LOPD, 8, LOPD shift-count width; may be narrower or wider than SIZE_EXP.
- SIZE_TAG, 1, sideband width (sign, lane index, etc.), carried unchanged.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept an input beat.
- i_overflow  in  1  mantissa carried out; exponent +1.
- i_underflow  in  1  mantissa already normalised; exponent unchanged.
- i_zero_flag  in  1  result mantissa is zero.
- i_lopd_value  in  SIZE_LOPD  left-shift count applied by the normaliser.
- i_exp_value  in  SIZE_EXP  pre-adjust biased exponent.
- i_tag  in  SIZE_TAG  sideband.
- i_clr_sticky  in  1  clear sticky flags.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the output beat.
- o_exp_result  out  SIZE_EXP  adjusted, range-limited exponent.
- o_tag  out  SIZE_TAG  sideband aligned with o_exp_result.
- o_exp_ovf  out  1  this beat saturated high.
- o_exp_unf  out  1  this beat flushed to zero.
- o_sticky_ovf  out  1  sticky OR of accepted o_exp_ovf.
- o_sticky_unf  out  1  sticky OR of accepted o_exp_unf.

Behaviour:
- Reset (async, i_rst=1): all stage valids, o_exp_result, o_tag, o_exp_ovf, o_exp_unf and both sticky flags go to 0.
- Two register stages (S1, S2). An input is accepted when i_valid & o_ready. It appears on the outputs exactly 2 cycles later when there is no backpressure.
- Flow control:
  - A stage loads when it is empty or when its content moves on in the same cycle.
  - o_ready = ~S1_valid | ~S2_valid | i_ready. Full throughput of 1 beat/cycle; no bubbles are inserted.
  - While o_valid=1 & i_ready=0, o_exp_result, o_tag and the flags hold stable.
  - Beats are never dropped or reordered.
- S1 arithmetic:
  - Form a signed intermediate E of width W = max(SIZE_EXP, SIZE_LOPD)+2. i_exp_value and i_lopd_value are zero-extended to W.
  - Precedence: i_overflow → E = exp+1. Else i_underflow → E = exp. Else E = exp − lopd.
  - i_overflow wins when both i_overflow and i_underflow are set.
  - Register E, i_zero_flag and i_tag.
- S2 classification, with MAX = 2^SIZE_EXP − 1:
  - zero_flag=1 → result 0, ovf=0, unf=0. This overrides everything.
  - Else E ≥ MAX → result MAX (all-ones), ovf=1.
  - Else E ≤ 0 → result 0, unf=1 (denormals are flushed).
  - Else result E[SIZE_EXP-1:0], no flags.
  - Register the result, flags and tag.
- Sticky flags:
  - Set on an output handshake (o_valid & i_ready) carrying the corresponding flag.
  - Cleared by i_clr_sticky.
  - If set and clear occur in the same cycle, set wins.
  - The sticky flags are independent of the stage valids.
- Reset asserted mid-operation: in-flight beats are discarded. o_valid falls asynchronously. o_ready is 1 in the first cycle after reset deasserts.

Test Plan (SIZE_EXP=8, SIZE_LOPD=5, SIZE_TAG=2):
- Plain normalise: exp=0x80, lopd=3, no flags, tag=2, i_ready=1 → 2 cycles later o_valid=1, o_exp_result=0x7D, o_tag=2, ovf=unf=0.
- Overflow and precedence: exp=0xFE with i_overflow=1 → 0xFF, o_exp_ovf=1. Then exp=0x10 with i_overflow=1 and i_underflow=1 → 0x11, no flags.
- Underflow flush and zero: exp=0x03, lopd=5 → 0x00, o_exp_unf=1. Then exp=0xFE, i_overflow=1, i_zero_flag=1 → 0x00, no flags.
- Backpressure:
  - Stimulus: stream exps 0x20, 0x21, 0x22, 0x23 (lopd=0, i_underflow=1) with i_i_ready held 0 for 4 cycles, then released.
  - Required: o_ready drops after 2 beats are held; the output holds 0x20 stable; after release the outputs are 0x20..0x23 in order with no loss or duplicates.
- Sticky: an accepted overflow beat sets o_sticky_ovf. i_clr_sticky in the same cycle as a new accepted overflow beat leaves it at 1. A clear alone drops it to 0 on the next cycle.
- Reset mid-stream: i_rst pulse while 2 beats are in flight → o_valid=0 immediately, all outputs 0, beats lost. A new beat after reset emerges 2 cycles after acceptance.
